// File: rtl/nios2_ocimem_arb_pkg.sv
// Shared types and constants for the OCI debug-RAM arbiter between the JTAG
// debug port and the CPU Avalon-MM slave port.
package nios2_ocimem_arb_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_J,
        GRANT_C,
        RDWAIT_J,
        RDWAIT_C
    } state_e;

endpackage

// File: rtl/nios2_ocimem_rr_arb.sv
// Two-way round-robin grant between the JTAG and CPU requesters.
// The history flag only advances on a contested grant.
module nios2_ocimem_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic i_req_j,
    input  logic i_req_c,
    input  logic i_take,
    output logic o_gnt_j,
    output logic o_gnt_c
);

    logic r_last_c;
    logic w_tie;

    assign w_tie   = i_req_j & i_req_c;
    assign o_gnt_j = i_req_j & (~i_req_c | r_last_c);
    assign o_gnt_c = i_req_c & ~o_gnt_j;

    // Resetting to "CPU granted last" lets JTAG win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_c <= 1'b1;
        end else if (i_take && w_tie) begin
            r_last_c <= o_gnt_c;
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates a single-port OCI debug RAM between JTAG and CPU (Avalon-MM).
// Optional address range check: define OCIMEM_RANGE_CHK_EN.
module nios2_ocimem_arbiter
    import nios2_ocimem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_addr_ld,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_rd_req,
    input  logic              jtag_wr_req,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_ready,
    output logic              jtag_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

`ifdef OCIMEM_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    state_e            r_state;
    logic              r_j_busy;
    logic              r_j_wr;
    logic              r_j_err;
    logic [ADDR_W-1:0] r_j_addr;
    logic [DATA_W-1:0] r_j_wdata;
    logic [DATA_W-1:0] r_jtag_rdata;
    logic              r_is_wr;
    logic              r_oor;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wren;
    logic [3:0]        r_ram_byteen;
    logic [DATA_W-1:0] r_ram_wdata;

    logic w_j_pulse;
    logic w_j_acc;
    logic w_c_req;
    logic w_gnt_j;
    logic w_gnt_c;
    logic w_oor_j;
    logic w_oor_c;
    logic w_c_wr_ok;

    assign w_j_pulse = jtag_rd_req | jtag_wr_req | jtag_addr_ld;
    assign w_j_acc   = jtag_rd_req | jtag_wr_req;
    assign w_c_req   = cpu_read | cpu_write;
    assign w_oor_j   = RANGE_CHK && (int'(r_j_addr) >= RAM_DEPTH);
    assign w_oor_c   = RANGE_CHK && (int'(cpu_address) >= RAM_DEPTH);
    assign w_c_wr_ok = cpu_write & ~w_oor_c;

    // r_j_busy covers both "pending" and "in service" for the JTAG side.
    nios2_ocimem_rr_arb u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req_j (r_j_busy),
        .i_req_c (w_c_req),
        .i_take  (r_state == IDLE),
        .o_gnt_j (w_gnt_j),
        .o_gnt_c (w_gnt_c)
    );

    // NOTE: state uses <= so every branch sees the pre-edge values; the async
    // reset clears the write strobe immediately, cancelling any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_j_busy     <= 1'b0;
            r_j_wr       <= 1'b0;
            r_j_err      <= 1'b0;
            r_j_addr     <= '0;
            r_j_wdata    <= '0;
            r_jtag_rdata <= '0;
            r_is_wr      <= 1'b0;
            r_oor        <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wren   <= 1'b0;
            r_ram_byteen <= '0;
            r_ram_wdata  <= '0;
        end else begin
            if (r_j_busy) begin
                if (w_j_pulse) r_j_err <= 1'b1;
            end else begin
                if (jtag_addr_ld) r_j_addr <= jtag_addr;
                if (w_j_acc) begin
                    r_j_busy  <= 1'b1;
                    r_j_wr    <= jtag_wr_req;
                    r_j_wdata <= jtag_wdata;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_gnt_j) begin
                        r_state      <= GRANT_J;
                        r_is_wr      <= r_j_wr;
                        r_oor        <= w_oor_j;
                        r_ram_addr   <= r_j_addr;
                        r_ram_wdata  <= r_j_wdata;
                        r_ram_wren   <= r_j_wr & ~w_oor_j;
                        r_ram_byteen <= (r_j_wr & ~w_oor_j) ? 4'hF : 4'h0;
                    end else if (w_gnt_c) begin
                        r_state      <= GRANT_C;
                        r_is_wr      <= cpu_write;
                        r_oor        <= w_oor_c;
                        r_ram_addr   <= cpu_address;
                        r_ram_wdata  <= cpu_writedata;
                        r_ram_wren   <= w_c_wr_ok;
                        r_ram_byteen <= w_c_wr_ok ? cpu_byteenable : 4'h0;
                    end
                end
                GRANT_J: begin
                    r_ram_wren   <= 1'b0;
                    r_ram_byteen <= 4'h0;
                    if (r_oor) r_j_err  <= 1'b1;
                    else       r_j_addr <= r_j_addr + ADDR_W'(1);
                    if (r_is_wr) begin
                        r_j_busy <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_state  <= RDWAIT_J;
                    end
                end
                RDWAIT_J: begin
                    r_jtag_rdata <= r_oor ? ERR_PATTERN : ram_rdata;
                    r_j_busy     <= 1'b0;
                    r_state      <= IDLE;
                end
                GRANT_C: begin
                    r_ram_wren   <= 1'b0;
                    r_ram_byteen <= 4'h0;
                    r_state      <= r_is_wr ? IDLE : RDWAIT_C;
                end
                RDWAIT_C: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign jtag_rdata      = r_jtag_rdata;
    assign jtag_ready      = ~r_j_busy;
    assign jtag_error      = r_j_err;
    assign cpu_waitrequest = ~(((r_state == GRANT_C) && r_is_wr) || (r_state == RDWAIT_C));
    assign cpu_readdata    = (r_state == RDWAIT_C) ? (r_oor ? ERR_PATTERN : ram_rdata) : '0;
    assign ram_addr        = r_ram_addr;
    assign ram_wren        = r_ram_wren;
    assign ram_byteen      = r_ram_byteen;
    assign ram_wdata       = r_ram_wdata;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: directed scenarios plus random
// traffic against a word-level memory model; honours OCIMEM_RANGE_CHK_EN.
module tb_nios2_ocimem_arbiter;

    localparam int ADDR_W    = 8;
    localparam int RAM_DEPTH = 64;
`ifdef OCIMEM_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              jtag_addr_ld = 1'b0;
    logic [ADDR_W-1:0] jtag_addr = '0;
    logic              jtag_rd_req = 1'b0;
    logic              jtag_wr_req = 1'b0;
    logic [31:0]       jtag_wdata = '0;
    logic [31:0]       jtag_rdata;
    logic              jtag_ready;
    logic              jtag_error;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [31:0]       cpu_writedata = '0;
    logic [3:0]        cpu_byteenable = '0;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    // Environment RAM: single port, one-cycle read latency.
    logic [31:0] ram [256] = '{default: '0};
    // Reference model: expected word contents and the JTAG address pointer.
    logic [31:0] exp_mem [256] = '{default: '0};
    logic [7:0]  jp = '0;

    int n_cmp = 0;
    int n_err = 0;

    nios2_ocimem_arbiter #(.ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .jtag_addr_ld    (jtag_addr_ld),
        .jtag_addr       (jtag_addr),
        .jtag_rd_req     (jtag_rd_req),
        .jtag_wr_req     (jtag_wr_req),
        .jtag_wdata      (jtag_wdata),
        .jtag_rdata      (jtag_rdata),
        .jtag_ready      (jtag_ready),
        .jtag_error      (jtag_error),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_byteenable  (cpu_byteenable),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .ram_addr        (ram_addr),
        .ram_wren        (ram_wren),
        .ram_byteen      (ram_byteen),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_jtag_rdata"},   jtag_rdata, 32'h0);
        check({p, "_jtag_ready"},   32'(jtag_ready), 32'd1);
        check({p, "_jtag_error"},   32'(jtag_error), 32'd0);
        check({p, "_cpu_wait"},     32'(cpu_waitrequest), 32'd1);
        check({p, "_cpu_readdata"}, cpu_readdata, 32'h0);
        check({p, "_ram_wren"},     32'(ram_wren), 32'd0);
        check({p, "_ram_byteen"},   32'(ram_byteen), 32'd0);
        check({p, "_ram_addr"},     32'(ram_addr), 32'd0);
        check({p, "_ram_wdata"},    ram_wdata, 32'h0);
    endtask

    // Uncontended JTAG access: pulse at cycle N, RAM access at N+2,
    // ready again at N+3 (write) or N+4 (read).
    task automatic jtag_access(input bit wr, input bit ld, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] ea;
        int k;
        if (ld) jp = a;
        ea = jp;
        jtag_addr = a; jtag_addr_ld = ld; jtag_wr_req = wr; jtag_rd_req = ~wr; jtag_wdata = d;
        @(negedge clk);
        jtag_addr_ld = 1'b0; jtag_wr_req = 1'b0; jtag_rd_req = 1'b0;
        k = 1;
        check("jtag_ready_pending", 32'(jtag_ready), 32'd0);
        while (!jtag_ready && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 2) begin
                check("jtag_ram_addr", 32'(ram_addr), 32'(ea));
                check("jtag_ram_wren", 32'(ram_wren), 32'(wr));
                if (wr) begin
                    check("jtag_ram_wdata", ram_wdata, d);
                    check("jtag_ram_byteen", 32'(ram_byteen), 32'hF);
                end
            end
        end
        check("jtag_latency", 32'(k), wr ? 32'd3 : 32'd4);
        if (wr) exp_mem[ea] = d;
        else    check("jtag_rdata", jtag_rdata, exp_mem[ea]);
        jp = jp + 8'd1;
    endtask

    // Uncontended CPU access: write completes 1 cycle, read 2 cycles after
    // the request is first seen.
    task automatic cpu_access(input bit wr, input bit rd_too, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] be);
        bit oor;
        int k;
        oor = RANGE_CHK && (int'(a) >= RAM_DEPTH);
        cpu_address = a; cpu_write = wr; cpu_read = ~wr | rd_too;
        cpu_writedata = d; cpu_byteenable = be;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cpu_waitrequest && k < 20);
        check("cpu_latency", 32'(k), wr ? 32'd1 : 32'd2);
        if (wr) begin
            check("cpu_ram_wren", 32'(ram_wren), 32'(!oor));
            check("cpu_ram_byteen", 32'(ram_byteen), oor ? 32'd0 : 32'(be));
            check("cpu_ram_addr", 32'(ram_addr), 32'(a));
            if (!oor) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            check("cpu_readdata", cpu_readdata, oor ? 32'hDEADBEEF : exp_mem[a]);
        end
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0;
        check("cpu_wait_one_cycle", 32'(cpu_waitrequest), 32'd1);
    endtask

    initial begin
        int k;
        #1 reset = 1'b1;
        #2 check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // JTAG write burst with auto-increment.
        jtag_access(1'b1, 1'b1, 8'h05, 32'h1111_1111);
        jtag_access(1'b1, 1'b0, 8'h00, 32'h2222_2222);
        check("burst_ram5", ram[5], 32'h1111_1111);
        check("burst_ram6", ram[6], 32'h2222_2222);
        check("burst_error", 32'(jtag_error), 32'd0);

        // CPU read latency and data.
        jtag_access(1'b1, 1'b1, 8'h03, 32'hCAFE_F00D);
        cpu_access(1'b0, 1'b0, 8'h03, 32'h0, 4'h0);

        // Contention: JTAG read and CPU write to 0x10 pending together.
        jtag_access(1'b1, 1'b1, 8'h10, 32'h5A5A_5A5A);
        jtag_addr = 8'h10; jtag_addr_ld = 1'b1; jtag_rd_req = 1'b1; jp = 8'h10;
        @(negedge clk);
        jtag_addr_ld = 1'b0; jtag_rd_req = 1'b0;
        cpu_address = 8'h10; cpu_write = 1'b1; cpu_writedata = 32'h0BAD_F00D; cpu_byteenable = 4'hF;
        @(negedge clk);
        check("tie1_j_addr", 32'(ram_addr), 32'h10);
        check("tie1_j_wren", 32'(ram_wren), 32'd0);
        check("tie1_c_wait", 32'(cpu_waitrequest), 32'd1);
        repeat (2) @(negedge clk);
        check("tie1_j_ready", 32'(jtag_ready), 32'd1);
        check("tie1_j_rdata", jtag_rdata, 32'h5A5A_5A5A);
        check("tie1_c_wait2", 32'(cpu_waitrequest), 32'd1);
        @(negedge clk);
        check("tie1_c_done", 32'(cpu_waitrequest), 32'd0);
        check("tie1_c_wren", 32'(ram_wren), 32'd1);
        check("tie1_c_wdata", ram_wdata, 32'h0BAD_F00D);
        exp_mem[8'h10] = 32'h0BAD_F00D;
        jp = 8'h11;
        @(negedge clk);
        cpu_write = 1'b0;
        jtag_rd_req = 1'b1;
        @(negedge clk);
        jtag_rd_req = 1'b0;
        cpu_address = 8'h10; cpu_read = 1'b1;
        @(negedge clk);
        check("tie2_c_addr", 32'(ram_addr), 32'h10);
        check("tie2_c_wren", 32'(ram_wren), 32'd0);
        check("tie2_j_ready", 32'(jtag_ready), 32'd0);
        @(negedge clk);
        check("tie2_c_done", 32'(cpu_waitrequest), 32'd0);
        check("tie2_c_rdata", cpu_readdata, 32'h0BAD_F00D);
        @(negedge clk);
        cpu_read = 1'b0;
        check("tie2_c_wait", 32'(cpu_waitrequest), 32'd1);
        @(negedge clk);
        check("tie2_j_addr", 32'(ram_addr), 32'h11);
        k = 0;
        while (!jtag_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("tie2_j_lat", 32'(k), 32'd2);
        check("tie2_j_rdata", jtag_rdata, exp_mem[8'h11]);
        jp = 8'h12;

        // CPU read+write together is a write; partial byte enables.
        cpu_access(1'b1, 1'b1, 8'h05, 32'hAABB_CCDD, 4'b0101);
        cpu_access(1'b0, 1'b0, 8'h05, 32'h0, 4'h0);

`ifdef OCIMEM_RANGE_CHK_EN
        cpu_access(1'b1, 1'b0, 8'h40, 32'h1234_5678, 4'hF);
        cpu_access(1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
`endif

        // Random uncontended traffic inside the implemented range.
        for (int i = 0; i < 40; i++) begin
            logic [7:0]  ra;
            logic [31:0] rd;
            bit          ld;
            ra = 8'($urandom_range(0, 59));
            rd = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    ld = (i == 0) || (jp >= 8'd60) || ($urandom_range(0, 1) == 1);
                    jtag_access(1'b1, ld, ra, rd);
                end
                1: begin
                    ld = (i == 0) || (jp >= 8'd60) || ($urandom_range(0, 1) == 1);
                    jtag_access(1'b0, ld, ra, rd);
                end
                2: cpu_access(1'b1, $urandom_range(0, 1) == 1, ra, rd, 4'($urandom_range(1, 15)));
                default: cpu_access(1'b0, 1'b0, ra, rd, 4'h0);
            endcase
        end

`ifndef OCIMEM_RANGE_CHK_EN
        // Address wrap from 0xFF to 0x00.
        jtag_access(1'b0, 1'b1, 8'hFF, 32'h0);
        jtag_access(1'b0, 1'b0, 8'h00, 32'h0);
`endif

        // Overrun: a second read pulse while the first is pending.
        jtag_addr = 8'h08; jtag_addr_ld = 1'b1; jtag_rd_req = 1'b1; jp = 8'h08;
        check("ovr_error_before", 32'(jtag_error), 32'd0);
        @(negedge clk);
        jtag_addr_ld = 1'b0;
        check("ovr_ready", 32'(jtag_ready), 32'd0);
        @(negedge clk);
        jtag_rd_req = 1'b0;
        k = 2;
        while (!jtag_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ovr_latency", 32'(k), 32'd4);
        check("ovr_rdata", jtag_rdata, exp_mem[8'h08]);
        check("ovr_error", 32'(jtag_error), 32'd1);
        jp = 8'h09;

        // Reset in GRANT_J of a write must cancel the write.
        jtag_addr = 8'h20; jtag_addr_ld = 1'b1; jtag_wr_req = 1'b1; jtag_wdata = ~exp_mem[8'h20];
        @(negedge clk);
        jtag_addr_ld = 1'b0; jtag_wr_req = 1'b0;
        @(negedge clk);
        check("rst_pre_wren", 32'(ram_wren), 32'd1);
        reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        check("rst_no_write", ram[8'h20], exp_mem[8'h20]);
        jp = 8'h00;
        jtag_access(1'b0, 1'b0, 8'h00, 32'h0);

        for (int i = 0; i < 256; i++) begin
            check($sformatf("mem_%02h", i), ram[i], exp_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
